digit_serial_add_sub: RTL and testbench
=======================================

Name: digit_serial_add_sub

Overview:
Parametrised, multi-cycle successor to the combinational ripple-carry adder/subtractor. It processes a WIDTH-bit add or subtract DIGIT bits per clock, from LSB to MSB, carrying between digits in a register. It uses a start/busy/done handshake and reports carry/borrow, signed overflow and zero flags. It sits in the arithmetic datapath where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
DIGIT, 2, bits processed per cycle; 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0 (elaboration-time check, fatal on violation).
NDIG (localparam), WIDTH/DIGIT, number of digit cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy==0
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
ctrl  input  1  0 = add (a+b), 1 = subtract (a-b), captured on accepted start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result outputs just updated
s  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
ovf  output  1  two's-complement signed overflow
zero  output  1  s == 0

Behaviour:
- Reset (rst_n low, async): state IDLE, busy=0, done=0, s=0, cout=0, ovf=0, zero=0, all internal registers 0. Reset takes effect immediately, including mid-operation. The in-flight operation is discarded and no done is produced.
- States: IDLE, RUN.
- IDLE, start=1 at edge k:
  - Latch opa=a, opb=(ctrl ? ~b : b), carry=ctrl, digit counter=0.
  - Go to RUN; busy=1 after edge k.
- RUN, each edge:
  - Digit i = counter adds opa[i*DIGIT +: DIGIT] + opb[i*DIGIT +: DIGIT] + carry.
  - The DIGIT-bit sum goes into a result shift register; carry is updated.
  - On the last digit (counter == NDIG-1), also capture the carry into the MSB position.
- Completion edge (edge k+NDIG):
  - Update s, cout=final carry, ovf=(carry into MSB) XOR (carry out of MSB), zero=(s==0).
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: exactly NDIG cycles from the accepting edge to done high. With NDIG==1, busy is high for one cycle.
- Result outputs hold their last value between completions. They change only at completion edges or on reset.
- start while busy=1 is ignored: no queueing, operands are not re-captured.
- start during the done cycle (busy=0) is accepted. Back-to-back operations therefore have a throughput of one per NDIG+1 cycles at most. done deasserts on the next edge while busy reasserts.
- a, b and ctrl are don't-care except at the accepting edge; changing them during RUN must not affect the result.
- Arithmetic: internal digit sum is DIGIT+1 bits wide. No saturation; wrap modulo 2^WIDTH.
- Result equals the combinational ripple adder/subtractor for all inputs.

Test Plan:
(Default WIDTH=8, DIGIT=2 unless stated.)
1. ctrl=0, a=8'h01, b=8'h00, start 1 cycle -> busy high 4 cycles; done at accept+4; s=8'h01, cout=0, ovf=0, zero=0.
2. ctrl=0, a=8'h7F, b=8'h01 -> s=8'h80, cout=0, ovf=1. Then a=8'hFF, b=8'h01 -> s=8'h00, cout=1, ovf=0, zero=1.
3. ctrl=1, a=8'h05, b=8'h03 -> s=8'h02, cout=1, ovf=0. Then a=8'h02, b=8'h04 -> s=8'hFE, cout=0, ovf=0. Then a=8'h80, b=8'h01 -> s=8'h7F, cout=1, ovf=1.
4. Handshake:
   - start re-pulsed with different a/b while busy, and a/b toggled during RUN -> ignored; result matches the first operands.
   - start asserted in the done cycle -> accepted; second done at +4 after that edge.
5. rst_n low two cycles after accept, mid-RUN -> busy, done, s and flags go 0 immediately with no clock; no done afterwards. A fresh add 8'h0B+8'h06 after release -> s=8'h11.
6. Parameter sweep:
   - WIDTH=4, DIGIT=1 (latency 4).
   - WIDTH=8, DIGIT=8 (latency 1).
   - WIDTH=16, DIGIT=4.
   Random 1000 ops each, add and subtract, checked against a golden (a±b) model including cout, ovf and zero.

Source files
------------

// File: rtl/digit_serial_add_sub_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The master drives start/operands; the slave returns busy/done/result/flags.
interface digit_serial_add_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ctrl;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output start, a, b, ctrl,
      input  busy, done, s, cout, ovf, zero
   );

   modport slave (
      input  start, a, b, ctrl,
      output busy, done, s, cout, ovf, zero
   );
endinterface

// File: rtl/digit_serial_add_sub.sv
// WIDTH-bit add/subtract processed DIGIT bits per clock, LSB first, with a
// registered inter-digit carry, start/busy/done handshake and carry/ovf/zero flags.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold their last value
// RUN   | one digit per clock for NDIG clocks; the last one completes
module digit_serial_add_sub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input logic                    clk,
   input logic                    rst_n,
   digit_serial_add_sub_if.slave  bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
      $fatal(1, "digit_serial_add_sub: illegal WIDTH/DIGIT combination");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_step;
   logic             w_last;

   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_s;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_done;

   logic [DIGIT:0]   w_sum;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             w_cin_msb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_cnt == CW'(NDIG - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operands shift right each digit, so the current digit is always the low slice.
   assign w_sum     = {1'b0, r_opa[DIGIT-1:0]} + {1'b0, r_opb[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, r_carry};
   assign w_acc_nxt = (r_acc >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
   // On the last digit the top slice bits are the operand MSBs: cin = a ^ b ^ sum.
   assign w_cin_msb = r_opa[DIGIT-1] ^ r_opb[DIGIT-1] ^ w_sum[DIGIT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_acc   <= '0;
         r_s     <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_load) begin
            r_opa   <= bus.a;
            r_opb   <= bus.ctrl ? ~bus.b : bus.b;
            r_carry <= bus.ctrl;
            r_cnt   <= '0;
            r_acc   <= '0;
         end else if (w_step) begin
            r_opa   <= r_opa >> DIGIT;
            r_opb   <= r_opb >> DIGIT;
            r_carry <= w_sum[DIGIT];
            r_cnt   <= r_cnt + 1'b1;
            r_acc   <= w_acc_nxt;
            if (w_last) begin
               r_s    <= w_acc_nxt;
               r_cout <= w_sum[DIGIT];
               r_ovf  <= w_cin_msb ^ w_sum[DIGIT];
               r_zero <= (w_acc_nxt == '0);
               r_done <= 1'b1;
            end
         end
      end
   end

   assign bus.busy = (r_state == RUN);
   assign bus.done = r_done;
   assign bus.s    = r_s;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;
   assign bus.zero = r_zero;
endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Bench for digit_serial_add_sub: directed W8/D2 vectors with hand-computed
// results, then random sweeps on W4/D1, W8/D8 and W16/D4 against an a+/-b model.
module tb_digit_serial_add_sub;
   logic clk;
   logic rst_n;
   logic sweep_go;
   int   n_tests;
   int   n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   digit_serial_add_sub_if #(.WIDTH(8)) m_if ();
   digit_serial_add_sub #(.WIDTH(8), .DIGIT(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic gold(input int w, input logic c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] s, output logic co, output logic ov, output logic z);
      logic [32:0] mask;
      logic [32:0] bb;
      logic [32:0] sum;
      mask = (33'd1 << w) - 33'd1;
      bb   = c ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
      sum  = ({1'b0, a} & mask) + bb + {32'd0, c};
      s    = 32'(sum & mask);
      co   = sum[w];
      ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
      z    = (s == 32'd0);
   endtask

   task automatic issue(input logic c, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      m_if.start = 1'b1;
      m_if.ctrl  = c;
      m_if.a     = a;
      m_if.b     = b;
      @(negedge clk);
      m_if.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int lat, output int nbusy);
      lat   = 0;
      nbusy = 0;
      while (m_if.done !== 1'b1 && lat < 40) begin
         if (m_if.busy === 1'b1) nbusy++;
         @(negedge clk);
         lat++;
      end
      if (m_if.done !== 1'b1) chk({tag, "_timeout"}, 32'(m_if.done), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic c, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec, input logic ev, input logic ez);
      int lat;
      int nbusy;
      issue(c, a, b);
      wait_done(tag, lat, nbusy);
      chk({tag, "_lat"},  32'(lat), 32'd4);
      chk({tag, "_busy"}, 32'(nbusy), 32'd4);
      chk({tag, "_s"},    32'(m_if.s), 32'(es));
      chk({tag, "_cout"}, 32'(m_if.cout), 32'(ec));
      chk({tag, "_ovf"},  32'(m_if.ovf), 32'(ev));
      chk({tag, "_zero"}, 32'(m_if.zero), 32'(ez));
      chk({tag, "_busy_at_done"}, 32'(m_if.busy), 32'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(m_if.done), 32'd0);
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W  = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
      localparam int D  = (g == 0) ? 1 : ((g == 1) ? 8 : 4);
      localparam int ND = W / D;
      logic fin;

      digit_serial_add_sub_if #(.WIDTH(W)) sif ();
      digit_serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (sif)
      );

      initial begin
         fin       = 1'b0;
         sif.start = 1'b0;
         sif.ctrl  = 1'b0;
         sif.a     = '0;
         sif.b     = '0;
         wait (sweep_go === 1'b1);
         for (int n = 0; n < 1000; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [31:0] es;
            logic        rc;
            logic        ec;
            logic        ev;
            logic        ez;
            int          lat;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            @(negedge clk);
            sif.start = 1'b1;
            sif.ctrl  = rc;
            sif.a     = ra[W-1:0];
            sif.b     = rb[W-1:0];
            @(negedge clk);
            sif.start = 1'b0;
            sif.a     = ~ra[W-1:0];
            sif.b     = ~rb[W-1:0];
            lat = 0;
            while (sif.done !== 1'b1 && lat < ND + 8) begin
               @(negedge clk);
               lat++;
            end
            gold(W, rc, ra, rb, es, ec, ev, ez);
            chk($sformatf("w%0d_lat", W),  32'(lat), 32'(ND));
            chk($sformatf("w%0d_s", W),    32'(sif.s), es);
            chk($sformatf("w%0d_cout", W), 32'(sif.cout), 32'(ec));
            chk($sformatf("w%0d_ovf", W),  32'(sif.ovf), 32'(ev));
            chk($sformatf("w%0d_zero", W), 32'(sif.zero), 32'(ez));
         end
         fin = 1'b1;
      end
   end

   initial begin
      int lat;
      int nbusy;
      int saw_done;
      int waited;
      n_tests    = 0;
      n_fail     = 0;
      sweep_go   = 1'b0;
      rst_n      = 1'b0;
      m_if.start = 1'b0;
      m_if.ctrl  = 1'b0;
      m_if.a     = 8'h00;
      m_if.b     = 8'h00;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(m_if.busy), 32'd0);
      chk("rst_done", 32'(m_if.done), 32'd0);
      chk("rst_s",    32'(m_if.s), 32'd0);
      chk("rst_flags", {29'd0, m_if.cout, m_if.ovf, m_if.zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("add_01_00", 1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
      run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
      run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
      run_op("sub_05_03", 1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0);
      run_op("sub_02_04", 1'b1, 8'h02, 8'h04, 8'hFE, 1'b0, 1'b0, 1'b0);
      run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      chk("hold_s",    32'(m_if.s), 32'h7F);
      chk("hold_ovf",  32'(m_if.ovf), 32'd1);

      // start re-pulsed with new operands while busy, operands toggled mid-run
      issue(1'b0, 8'h10, 8'h22);
      m_if.start = 1'b1;
      m_if.ctrl  = 1'b1;
      m_if.a     = 8'hAA;
      m_if.b     = 8'h55;
      @(negedge clk);
      m_if.a     = 8'h0F;
      m_if.b     = 8'hF0;
      m_if.ctrl  = 1'b0;
      @(negedge clk);
      m_if.start = 1'b0;
      wait_done("ign", lat, nbusy);
      chk("ign_lat",  32'(lat), 32'd2);
      chk("ign_s",    32'(m_if.s), 32'h32);
      chk("ign_cout", 32'(m_if.cout), 32'd0);
      saw_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_if.done === 1'b1 || m_if.busy === 1'b1) saw_done++;
      end
      chk("ign_no_second_op", 32'(saw_done), 32'd0);

      // start presented in the done cycle
      issue(1'b0, 8'h03, 8'h04);
      wait_done("b2b1", lat, nbusy);
      chk("b2b1_s", 32'(m_if.s), 32'h07);
      m_if.start = 1'b1;
      m_if.ctrl  = 1'b1;
      m_if.a     = 8'h20;
      m_if.b     = 8'h01;
      @(negedge clk);
      m_if.start = 1'b0;
      chk("b2b_busy_re", 32'(m_if.busy), 32'd1);
      chk("b2b_done_lo", 32'(m_if.done), 32'd0);
      wait_done("b2b2", lat, nbusy);
      chk("b2b2_lat",  32'(lat), 32'd4);
      chk("b2b2_s",    32'(m_if.s), 32'h1F);
      chk("b2b2_cout", 32'(m_if.cout), 32'd1);
      chk("b2b2_ovf",  32'(m_if.ovf), 32'd0);

      // async reset in the middle of a run
      issue(1'b0, 8'h33, 8'h44);
      @(negedge clk);
      chk("mid_busy", 32'(m_if.busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",  32'(m_if.busy), 32'd0);
      chk("arst_done",  32'(m_if.done), 32'd0);
      chk("arst_s",     32'(m_if.s), 32'd0);
      chk("arst_flags", {29'd0, m_if.cout, m_if.ovf, m_if.zero}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_if.done === 1'b1) saw_done++;
      end
      chk("arst_no_done", 32'(saw_done), 32'd0);
      run_op("post_rst", 1'b0, 8'h0B, 8'h06, 8'h11, 1'b0, 1'b0, 1'b0);

      sweep_go = 1'b1;
      waited   = 0;
      while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && waited < 30000) begin
         @(negedge clk);
         waited++;
      end
      if (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin))
         chk("sweep_timeout", {29'd0, g_sw[2].fin, g_sw[1].fin, g_sw[0].fin}, 32'd7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
